// File: rtl/dataset_ram_if.sv
// Bus bundle for the dataset RAM: write port, random-read port, clear control
// and the valid/ready row stream toward the regression datapath.
interface dataset_ram_if #(
  parameter int ADDR_WIDTH   = 3,
  parameter int MAX_FEATURES = 7,
  parameter int LANE_WIDTH   = 16,
  parameter int DATA_WIDTH   = LANE_WIDTH * (MAX_FEATURES + 1)
);
  logic                    clr;
  logic                    busy;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [MAX_FEATURES:0]   wr_mask;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    st_start;
  logic [ADDR_WIDTH-1:0]   st_first;
  logic [ADDR_WIDTH-1:0]   st_last;
  logic [DATA_WIDTH-1:0]   st_data;
  logic [ADDR_WIDTH-1:0]   st_addr;
  logic                    st_valid;
  logic                    st_ready;
  logic                    st_done;

  modport master (
    output clr, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
           st_start, st_first, st_last, st_ready,
    input  busy, rd_data, rd_valid, st_data, st_addr, st_valid, st_done
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr,
           st_start, st_first, st_last, st_ready,
    output busy, rd_data, rd_valid, st_data, st_addr, st_valid, st_done
  );
endinterface

// File: rtl/dataset_ram.sv
// Training-data RAM: row 0 holds weights, rows 1..DEPTH-1 data points.
// Masked writes, clear sweep, random reads and a valid/ready row stream.
module dataset_ram #(
  parameter int ADDR_WIDTH   = 3,
  parameter int DEPTH        = 7,
  parameter int MAX_FEATURES = 7,
  parameter int LANE_WIDTH   = 16,
  parameter int DATA_WIDTH   = LANE_WIDTH * (MAX_FEATURES + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  dataset_ram_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, FETCH, HOLD} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic                  st_done_q, st_done_d;

  logic                  wr_in_range, rd_in_range, st_range_ok;
  logic [DATA_WIDTH-1:0] wr_bits;

  assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH_C;
  assign st_range_ok = (bus.st_first <= bus.st_last) && ({1'b0, bus.st_last} < DEPTH_C);

  always_comb begin
    wr_bits = '0;
    for (int k = 0; k <= MAX_FEATURES; k++)
      wr_bits[LANE_WIDTH*k +: LANE_WIDTH] = {LANE_WIDTH{bus.wr_mask[k]}};
  end

  // Storage is deliberately outside reset; only the clear sweep zeroes it.
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (bus.wr_en && wr_in_range) begin
      mem[bus.wr_addr] <= (mem[bus.wr_addr] & ~wr_bits) | (bus.wr_data & wr_bits);
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_d      = cur_q;
    last_d     = last_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    st_data_d  = st_data_q;
    st_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (bus.st_start) begin
          if (st_range_ok) begin
            cur_d   = bus.st_first;
            last_d  = bus.st_last;
            state_d = FETCH;
          end else begin
            st_done_d = 1'b1;
          end
        end else if (bus.rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_in_range ? mem[bus.rd_addr] : '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_C) state_d = IDLE;
      end
      FETCH: begin
        st_data_d = mem[cur_q];
        state_d   = HOLD;
      end
      HOLD: begin
        if (bus.st_ready) begin
          if (cur_q == last_q) begin
            state_d   = IDLE;
            st_done_d = 1'b1;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cur_q      <= '0;
      last_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      st_data_q  <= '0;
      st_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      st_data_q  <= st_data_d;
      st_done_q  <= st_done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.st_data  = st_data_q;
  assign bus.st_addr  = cur_q;
  assign bus.st_valid = (state_q == HOLD);
  assign bus.st_done  = st_done_q;

endmodule

// File: tb/tb_dataset_ram.sv
// Scoreboard bench for dataset_ram: stimulus pushes expectations from an array
// model of the rows; a negedge monitor pops them as the DUT responds.
module tb_dataset_ram;
  localparam int AW    = 3;
  localparam int DEPTH = 7;
  localparam int MF    = 7;
  localparam int LW    = 16;
  localparam int DW    = LW * (MF + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  dataset_ram_if #(.ADDR_WIDTH(AW), .MAX_FEATURES(MF), .LANE_WIDTH(LW)) bus ();

  dataset_ram #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_FEATURES(MF), .LANE_WIDTH(LW)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef struct {logic [DW-1:0] data; int unsigned cyc;} rd_exp_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} beat_t;
  typedef struct {bit invalid; int unsigned cyc;} done_t;

  rd_exp_t rd_q[$];
  beat_t   beat_q[$];
  done_t   done_q[$];
  int unsigned xfer_cyc[$];

  logic [DW-1:0] model [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int unsigned last_xfer_cyc = 0;

  logic          hold_active = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;
  rd_exp_t re;
  beat_t   be;
  done_t   de;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_i(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: compares every DUT response against the queued expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_active = 1'b0;
    end else begin
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) check_i("rd_valid_unexpected", 1, 0);
        else begin
          re = rd_q.pop_front();
          check("rd_data", bus.rd_data, re.data);
          check_i("rd_latency", int'(cyc), int'(re.cyc));
        end
      end
      if (bus.st_valid) begin
        if (hold_active) begin
          check("st_hold_data", bus.st_data, hold_data);
          check_i("st_hold_addr", int'(bus.st_addr), int'(hold_addr));
        end
        if (bus.st_ready) begin
          hold_active = 1'b0;
          beat_cnt++;
          last_xfer_cyc = cyc;
          xfer_cyc.push_back(cyc);
          if (beat_q.size() == 0) check_i("beat_unexpected", 1, 0);
          else begin
            be = beat_q.pop_front();
            check_i("st_addr", int'(bus.st_addr), int'(be.addr));
            check("st_data", bus.st_data, be.data);
          end
        end else begin
          hold_active = 1'b1;
          hold_data   = bus.st_data;
          hold_addr   = bus.st_addr;
        end
      end
      if (bus.st_done) begin
        done_cnt++;
        if (done_q.size() == 0) check_i("done_unexpected", 1, 0);
        else begin
          de = done_q.pop_front();
          if (de.invalid) check_i("done_cycle_rejected", int'(cyc), int'(de.cyc));
          else begin
            check_i("done_cycle", int'(cyc), int'(last_xfer_cyc + 1));
            check_i("beats_left_at_done", beat_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic [MF:0] m, logic [DW-1:0] d);
    if (int'(a) < DEPTH)
      for (int k = 0; k <= MF; k++)
        if (m[k]) model[a][LW*k +: LW] = d[LW*k +: LW];
  endfunction

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    if (int'(a) < DEPTH) return model[a];
    return '0;
  endfunction

  task automatic do_write(logic [AW-1:0] a, logic [MF:0] m, logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_mask = m; bus.wr_data = d;
    model_write(a, m, d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_read(logic [AW-1:0] a);
    rd_q.push_back('{data: model_read(a), cyc: cyc + 1});
    bus.rd_en = 1'b1; bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic do_rw(logic [AW-1:0] a, logic [MF:0] m, logic [DW-1:0] d);
    rd_q.push_back('{data: model_read(a), cyc: cyc + 1});
    model_write(a, m, d);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_mask = m; bus.wr_data = d;
    tick();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  task automatic push_stream(logic [AW-1:0] f, logic [AW-1:0] l);
    bit ok;
    ok = (f <= l) && (int'(l) < DEPTH);
    if (ok)
      for (int r = int'(f); r <= int'(l); r++)
        beat_q.push_back('{addr: AW'(r), data: model[r]});
    done_q.push_back('{invalid: !ok, cyc: cyc + 1});
    bus.st_start = 1'b1; bus.st_first = f; bus.st_last = l;
    tick();
    bus.st_start = 1'b0;
  endtask

  task automatic wait_done(bit rnd_ready);
    int i;
    for (i = 0; i < 400; i++) begin
      if (done_q.size() == 0) break;
      if (rnd_ready) bus.st_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check_i("stream_completes", done_q.size(), 0);
    bus.st_ready = 1'b1;
  endtask

  task automatic wait_valid();
    int i;
    for (i = 0; i < 20; i++) begin
      tick();
      if (bus.st_valid) break;
    end
    check_i("st_valid_arrives", int'(bus.st_valid), 1);
  endtask

  int b0, d0, busy_cnt;
  logic [AW-1:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    bus.clr = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.st_start = 0; bus.st_first = '0; bus.st_last = '0;
    bus.st_ready = 1'b1;
    repeat (3) tick();
    check_i("rst_busy", int'(bus.busy), 0);
    check("rst_rd_data", bus.rd_data, '0);
    check_i("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_st_data", bus.st_data, '0);
    check_i("rst_st_addr", int'(bus.st_addr), 0);
    check_i("rst_st_valid", int'(bus.st_valid), 0);
    check_i("rst_st_done", int'(bus.st_done), 0);
    rst_n = 1'b1;
    tick();

    // Bring the array to a known state.
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    repeat (DEPTH + 2) tick();
    for (int r = 0; r < DEPTH; r++) model[r] = '0;

    // Masked write.
    do_write(3'd2, 8'hFF, {8{16'h1111}});
    do_write(3'd2, 8'h01, {8{16'hABCD}});
    do_read(3'd2);
    check("masked_row2", bus.rd_data, {{7{16'h1111}}, 16'hABCD});

    // Stream rows 1..3 at full rate.
    for (int r = 1; r <= 3; r++) do_write(AW'(r), 8'hFF, rnd_row());
    xfer_cyc.delete(); d0 = done_cnt;
    push_stream(3'd1, 3'd3);
    wait_done(1'b0);
    check_i("full_rate_beats", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check_i("beat_gap_1", int'(xfer_cyc[1] - xfer_cyc[0]), 2);
      check_i("beat_gap_2", int'(xfer_cyc[2] - xfer_cyc[1]), 2);
    end
    check_i("full_rate_done_count", done_cnt - d0, 1);
    check_i("busy_after_stream", int'(bus.busy), 0);

    // Backpressure on beat 2.
    b0 = beat_cnt;
    push_stream(3'd1, 3'd3);
    for (int i = 0; i < 20 && beat_cnt < b0 + 1; i++) tick();
    bus.st_ready = 1'b0;
    repeat (6) tick();
    check_i("bp_stalled_valid", int'(bus.st_valid), 1);
    check_i("bp_stalled_addr", int'(bus.st_addr), 2);
    bus.st_ready = 1'b1;
    wait_done(1'b0);
    check_i("bp_beat_count", beat_cnt - b0, 3);

    // Clear sweep with a write and a read issued while busy.
    for (int r = 0; r < DEPTH; r++) do_write(AW'(r), 8'hFF, rnd_row() | 128'h1);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_mask = 8'hFF; bus.wr_data = {8{16'h5A5A}};
        bus.rd_en = 1'b1; bus.rd_addr = 3'd4;
      end
      if (i == 2) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
      if (bus.busy) busy_cnt++;
      tick();
    end
    check_i("clear_busy_cycles", busy_cnt, DEPTH);
    for (int r = 0; r < DEPTH; r++) model[r] = '0;
    for (int r = 0; r < DEPTH; r++) do_read(AW'(r));

    // Boundaries.
    d0 = done_cnt; b0 = beat_cnt;
    push_stream(3'd4, 3'd2);
    repeat (3) tick();
    check_i("rejected_done_count", done_cnt - d0, 1);
    check_i("rejected_no_beats", beat_cnt - b0, 0);
    do_write(3'd7, 8'hFF, rnd_row());
    do_read(3'd7);
    do_write(3'd1, 8'hFF, {8{16'h0101}});
    do_rw(3'd1, 8'hFF, {8{16'h0202}});
    check("rw_old_value", bus.rd_data, {8{16'h0101}});
    do_read(3'd1);

    // Reset during HOLD of beat 2.
    for (int r = 1; r <= 3; r++) do_write(AW'(r), 8'hFF, rnd_row());
    bus.st_ready = 1'b0;
    push_stream(3'd1, 3'd3);
    wait_valid();
    bus.st_ready = 1'b1; tick(); bus.st_ready = 1'b0;
    wait_valid();
    check_i("pre_reset_addr", int'(bus.st_addr), 2);
    rst_n = 1'b0;
    #1;
    check_i("mid_rst_st_valid", int'(bus.st_valid), 0);
    check_i("mid_rst_st_done", int'(bus.st_done), 0);
    check_i("mid_rst_busy", int'(bus.busy), 0);
    beat_q.delete(); done_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    bus.st_ready = 1'b1;
    tick();
    for (int r = 0; r < DEPTH; r++) do_read(AW'(r));
    push_stream(3'd1, 3'd3);
    wait_done(1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      ra = AW'($urandom_range(0, 7));
      rb = AW'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0, 1: do_write(ra, 8'($urandom()), rnd_row());
        2:    do_read(ra);
        3:    do_rw(ra, 8'($urandom()), rnd_row());
        default: begin
          push_stream(ra, rb);
          wait_done(1'b1);
        end
      endcase
    end

    for (int i = 0; i < 50; i++) begin
      if (rd_q.size() == 0 && beat_q.size() == 0 && done_q.size() == 0) break;
      tick();
    end
    check_i("rd_queue_drained", rd_q.size(), 0);
    check_i("beat_queue_drained", beat_q.size(), 0);
    check_i("done_queue_drained", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dataset_ram.md
# dataset_ram

Synchronous, parametrised successor to the training-data RAM. It holds row 0 (weights) and rows 1..DEPTH-1 (data points), each row being MAX_FEATURES feature lanes plus one y lane. It replaces the tri-state bus with separate write and read ports, and adds per-lane write masking, a hardware clear sweep, and a valid/ready row-streaming engine that feeds the regression datapath.

## Interface
- ADDR_WIDTH, 3, row address width
- DEPTH, 7, number of rows (row 0 = weights), DEPTH ≤ 2^ADDR_WIDTH
- MAX_FEATURES, 7, feature lanes per row (lane MAX_FEATURES = y value)
- LANE_WIDTH, 16, bits per lane
- DATA_WIDTH, LANE_WIDTH*(MAX_FEATURES+1), row width
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- clr  in  1  start clear sweep (zero all rows)
- busy  out  1  clear or stream in progress
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write row
- wr_mask  in  MAX_FEATURES+1  lane enables; bit k covers bits [LANE_WIDTH*k +: LANE_WIDTH]
- wr_data  in  DATA_WIDTH  write row data
- rd_en  in  1  random read strobe
- rd_addr  in  ADDR_WIDTH  read row
- rd_data  out  DATA_WIDTH  read result
- rd_valid  out  1  one-cycle pulse, rd_data updated
- st_start  in  1  start stream of rows st_first..st_last
- st_first, st_last  in  ADDR_WIDTH  inclusive stream range
- st_data  out  DATA_WIDTH  streamed row
- st_addr  out  ADDR_WIDTH  row index of st_data
- st_valid  out  1  st_data valid
- st_ready  in  1  consumer accepts beat
- st_done  out  1  one-cycle pulse after the last beat, or after a rejected start

## Operation
- FSM states: IDLE, CLEAR, FETCH, HOLD. busy = (state != IDLE).
- IDLE: clr has priority over st_start, which has priority over rd_en. clr enters CLEAR with sweep pointer 0.
- CLEAR: writes 0 to row ptr every cycle and increments ptr. After row DEPTH-1 it returns to IDLE, so busy is high for exactly DEPTH cycles. wr_en is ignored during CLEAR.
- Valid st_start (st_first ≤ st_last < DEPTH): latch the range, set cur = st_first, go to FETCH.
- Invalid st_start: stay IDLE, pulse st_done on the next cycle, emit no beats.
- FETCH: sync-read mem[cur], go to HOLD.
- HOLD: st_valid=1, st_data=row, st_addr=cur. Data and address stay stable until st_valid & st_ready.
  - Transfer with cur==st_last: go to IDLE, st_valid=0, pulse st_done.
  - Transfer otherwise: cur+1, go to FETCH.
- Writes outside CLEAR are accepted in every state. Only lanes with wr_mask[k]=1 change. A mask of 0 is a no-op.
- wr_addr ≥ DEPTH: write dropped. Reads with rd_addr ≥ DEPTH return 0.
- rd_en is ignored while busy: no rd_valid, rd_data unchanged.
- Same-cycle read and write to the same row: the read returns old data (read-before-write). A write to a row not yet fetched by the stream is visible in that row's beat.
- clr and st_start are ignored while busy.
- Memory array is not reset by RST_N; only clr zeroes it.

## Timing
- Reset (async assert, sync release): state IDLE, busy 0, rd_data 0, rd_valid 0, st_data 0, st_addr 0, st_valid 0, st_done 0. Reset mid-clear or mid-stream aborts the operation. Rows already written keep their contents.
- Write: takes effect at the edge where wr_en=1; readable from the next cycle.
- Random read: rd_en at edge n gives rd_data/rd_valid valid after edge n+1. rd_valid lasts one cycle; rd_data holds until the next accepted read.
- Stream: st_start at edge 0 enters FETCH; st_valid rises after edge 1. Each beat costs 1 FETCH cycle plus ≥1 HOLD cycle, so the maximum rate is one row per 2 cycles with st_ready held high.
- st_done rises one cycle after the last transfer edge and is high for 1 cycle; busy falls in the same cycle.
- Clear: clr at edge 0 makes busy high for cycles 1..DEPTH. A row read issued after busy falls returns 0.

## Test plan
- Reset, then masked write: wr row 2 with mask 0xFF and data all 0x1111; write row 2 with mask 0x01 and data all 0xABCD -> a read of row 2 gives lane0=0xABCD, lanes1..7=0x1111, with rd_valid one cycle after rd_en.
- Stream rows 1..3 with st_ready=1 -> three beats, st_addr 1,2,3 each with the correct data and 2 cycles apart; st_done pulses once; busy drops.
- Stream backpressure: st_ready low for 5 cycles during beat 2 -> st_data and st_addr stay stable, no beat is lost or duplicated, and the total beat count is 3.
- Clear: fill all rows with nonzero data, pulse clr -> busy high for exactly 7 cycles and every row reads 0. A wr_en issued during the sweep is lost. rd_en during busy gives no rd_valid.
- Boundaries: st_first=4, st_last=2 -> no st_valid and st_done one cycle later. wr_addr=7 (≥DEPTH) is dropped; rd_addr=7 returns 0. Same-cycle read and write to row 1 returns the old value.
- Reset mid-stream: assert RST_N low during HOLD of beat 2 -> st_valid, st_done and busy go 0 immediately. After release the memory contents are intact and a new stream works.
